// File: rtl/led_matrix_pkg.sv
// Shared types and geometry for the LED matrix driver.
package led_matrix_pkg;
  localparam int unsigned ROWS       = 16;
  localparam int unsigned COLS       = 16;
  localparam int unsigned SHIFT_BITS = 32;
  localparam int unsigned ROW_W      = $clog2(ROWS);

  typedef enum logic [1:0] {LOAD, SHIFT, LATCH, DWELL} state_e;
endpackage

// File: rtl/led_shift_serializer.sv
// 32-bit parallel-in/serial-out shifter; two phases per bit (sr_clk low, then high).
module led_shift_serializer
  import led_matrix_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  shift_en_i,
  input  logic [SHIFT_BITS-1:0] word_i,
  output logic                  sr_data_o,
  output logic                  sr_clk_o,
  output logic                  done_o
);
  localparam int unsigned CW = $clog2(2 * SHIFT_BITS);

  logic [SHIFT_BITS-1:0] word_q, word_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      word_d = word_i;
      cnt_d  = '0;
    end else if (shift_en_i) begin
      cnt_d = cnt_q + 1'b1;
      // advance to the next bit after its high phase
      if (cnt_q[0]) word_d = {word_q[SHIFT_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sr_data_o = shift_en_i & word_q[SHIFT_BITS-1];
  assign sr_clk_o  = shift_en_i & cnt_q[0];
  assign done_o    = shift_en_i & (cnt_q == '1);
endmodule

// File: rtl/led_matrix_driver.sv
// Row-scanned 16x16 red/green LED matrix driver. Optional macro
// LED_DRIVER_BRIGHTNESS_EN adds a 4-bit brightness input gating oe_n in DWELL.
module led_matrix_driver
  import led_matrix_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ROWS-1:0][COLS-1:0] RedPixels,
  input  logic [ROWS-1:0][COLS-1:0] GrnPixels,
`ifdef LED_DRIVER_BRIGHTNESS_EN
  input  logic [3:0]                brightness,
`endif
  output logic                      sr_data,
  output logic                      sr_clk,
  output logic                      sr_latch,
  output logic [ROWS-1:0]           row_sel,
  output logic                      oe_n,
  output logic                      frame_sync
);
  state_e                    state_q, state_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic [15:0]               dwell_q, dwell_d;
  logic [ROWS-1:0][COLS-1:0] red_q, grn_q;
  logic [ROWS-1:0][COLS-1:0] red_src, grn_src;
  logic [SHIFT_BITS-1:0]     word;
  logic                      capture, ser_load, shift_en, shift_done, lit;

  // Row 0 shifts straight from the inputs being captured this cycle.
  assign red_src = capture ? RedPixels : red_q;
  assign grn_src = capture ? GrnPixels : grn_q;
  assign word    = {red_src[row_q], grn_src[row_q]};

`ifdef LED_DRIVER_BRIGHTNESS_EN
  logic [3:0]  bright_q;
  logic [20:0] on_cycles;
  assign on_cycles = ((21'(bright_q) + 21'd1) * 21'(DWELL_CYCLES)) >> 4;
  assign lit       = 21'(dwell_q) < on_cycles;

  always_ff @(posedge clk) begin
    if (reset)                bright_q <= '0;
    else if (state_q == LOAD) bright_q <= brightness;
  end
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    dwell_d    = dwell_q;
    capture    = 1'b0;
    ser_load   = 1'b0;
    shift_en   = 1'b0;
    sr_latch   = 1'b0;
    row_sel    = '0;
    oe_n       = 1'b1;
    frame_sync = 1'b0;
    if (!reset) begin
      unique case (state_q)
        LOAD: begin
          ser_load   = 1'b1;
          capture    = (row_q == '0);
          frame_sync = capture;
          state_d    = SHIFT;
        end
        SHIFT: begin
          shift_en = 1'b1;
          if (shift_done) state_d = LATCH;
        end
        LATCH: begin
          sr_latch = 1'b1;
          dwell_d  = '0;
          state_d  = DWELL;
        end
        DWELL: begin
          row_sel[row_q] = 1'b1;
          oe_n           = ~lit;
          if (dwell_q == 16'(DWELL_CYCLES - 1)) begin
            dwell_d = '0;
            row_d   = row_q + 1'b1;
            state_d = LOAD;
          end else begin
            dwell_d = dwell_q + 16'd1;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      row_q   <= '0;
      dwell_q <= '0;
      red_q   <= '0;
      grn_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      dwell_q <= dwell_d;
      if (capture) begin
        red_q <= RedPixels;
        grn_q <= GrnPixels;
      end
    end
  end

  led_shift_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .load_i    (ser_load),
    .shift_en_i(shift_en),
    .word_i    (word),
    .sr_data_o (sr_data),
    .sr_clk_o  (sr_clk),
    .done_o    (shift_done)
  );
endmodule

// File: tb/tb_led_matrix_driver.sv
// Self-checking bench for led_matrix_driver: vector table plus multi-cycle sequences.
module tb_led_matrix_driver;
`ifdef LED_DRIVER_BRIGHTNESS_EN
  localparam int D = 16;
  localparam logic OE_END = 1'b1;
`else
  localparam int D = 4;
  localparam logic OE_END = 1'b0;
`endif
  localparam int P = 66 + D;
  localparam int F = 16 * P;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0][15:0] red, grn;
  logic sr_data, sr_clk, sr_latch, oe_n, frame_sync;
  logic [15:0] row_sel;
`ifdef LED_DRIVER_BRIGHTNESS_EN
  logic [3:0] brightness = 4'd3;
`endif

  always #5 clk = ~clk;

  led_matrix_driver #(.DWELL_CYCLES(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .RedPixels (red),
    .GrnPixels (grn),
`ifdef LED_DRIVER_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .sr_data   (sr_data),
    .sr_clk    (sr_clk),
    .sr_latch  (sr_latch),
    .row_sel   (row_sel),
    .oe_n      (oe_n),
    .frame_sync(frame_sync)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string name);
    chk(name, {sr_data, sr_clk, sr_latch, row_sel, oe_n, frame_sync},
        {1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
  endtask

  typedef struct {
    int          cyc;
    logic        fs;
    logic        latch;
    logic [15:0] rs;
    logic        oe_n;
    logic        sclk;
    logic        sdata;
  } vec_t;

  vec_t        tbl[14];
  logic [31:0] words[2][16];
  int          latches;
  int          oe_low[16];

  task automatic run(input int ncyc, input bit change_px);
    logic [31:0] acc;
    int nb, row, frm;
    bit ok;
    acc = '0;
    nb = 0;
    latches = 0;
    for (int r = 0; r < 16; r++) oe_low[r] = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) reset = 1'b0;
      if (change_px && c == 2 * P + 10) red[3] = 16'hFFFF;
`ifdef LED_DRIVER_BRIGHTNESS_EN
      if (c == 68) brightness = 4'd15;
`endif
      @(negedge clk);
      row = (c % F) / P;
      frm = c / F;
      for (int i = 0; i < 14; i++)
        if (tbl[i].cyc == c)
          chk($sformatf("vec_c%0d", c),
              {frame_sync, sr_latch, row_sel, oe_n, sr_clk, sr_data},
              {tbl[i].fs, tbl[i].latch, tbl[i].rs, tbl[i].oe_n, tbl[i].sclk, tbl[i].sdata});
      chk($sformatf("frame_sync_c%0d", c), frame_sync, ((c % F) == 0));
      ok = ((oe_n == 1'b0) ? (row_sel != 16'h0) : 1'b1) && $onehot0(row_sel)
           && !(sr_latch && row_sel != 16'h0);
      chk($sformatf("invariant_c%0d", c), ok, 1'b1);
      if (sr_clk) begin
        acc = {acc[30:0], sr_data};
        nb++;
      end
      if (!oe_n && frm == 0) oe_low[row]++;
      if (sr_latch) begin
        chk($sformatf("bits_before_latch_c%0d", c), nb, 32);
        if (frm < 2) words[frm][row] = acc;
        nb = 0;
        latches++;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{0,          1'b1, 1'b0, 16'h0000, 1'b1,   1'b0, 1'b0};
    tbl[1]  = '{1,          1'b0, 1'b0, 16'h0000, 1'b1,   1'b0, 1'b1};
    tbl[2]  = '{2,          1'b0, 1'b0, 16'h0000, 1'b1,   1'b1, 1'b1};
    tbl[3]  = '{3,          1'b0, 1'b0, 16'h0000, 1'b1,   1'b0, 1'b0};
    tbl[4]  = '{5,          1'b0, 1'b0, 16'h0000, 1'b1,   1'b0, 1'b1};
    tbl[5]  = '{64,         1'b0, 1'b0, 16'h0000, 1'b1,   1'b1, 1'b1};
    tbl[6]  = '{65,         1'b0, 1'b1, 16'h0000, 1'b1,   1'b0, 1'b0};
    tbl[7]  = '{66,         1'b0, 1'b0, 16'h0001, 1'b0,   1'b0, 1'b0};
    tbl[8]  = '{P - 1,      1'b0, 1'b0, 16'h0001, OE_END, 1'b0, 1'b0};
    tbl[9]  = '{P,          1'b0, 1'b0, 16'h0000, 1'b1,   1'b0, 1'b0};
    tbl[10] = '{P + 66,     1'b0, 1'b0, 16'h0002, 1'b0,   1'b0, 1'b0};
    tbl[11] = '{15 * P + 66, 1'b0, 1'b0, 16'h8000, 1'b0,  1'b0, 1'b0};
    tbl[12] = '{F,          1'b1, 1'b0, 16'h0000, 1'b1,   1'b0, 1'b0};
    tbl[13] = '{F + 66,     1'b0, 1'b0, 16'h0001, 1'b0,   1'b0, 1'b0};

    red = '0;
    grn = '0;
    red[0] = 16'hA5A5;
    grn[0] = 16'h0F0F;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 16; r++) words[f][r] = 32'hDEAD_BEEF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset_outputs");

    run(2 * F, 1'b1);
    chk("row0_word_f0", words[0][0], 32'hA5A5_0F0F);
    chk("row2_word_f0", words[0][2], 32'h0000_0000);
    chk("row3_word_f0", words[0][3], 32'h0000_0000);
    chk("row0_word_f1", words[1][0], 32'hA5A5_0F0F);
    chk("row3_word_f1", words[1][3], 32'hFFFF_0000);
    chk("latch_count", latches, 32);
`ifdef LED_DRIVER_BRIGHTNESS_EN
    chk("oe_low_row0_b3", oe_low[0], 4);
    chk("oe_low_row1_b15", oe_low[1], 16);
`else
    chk("oe_low_row0", oe_low[0], D);
    chk("oe_low_row1", oe_low[1], D);
`endif

    // Run into row 7 SHIFT of the third frame, then reset mid-shift.
    repeat (7 * P + 11) @(posedge clk);
    @(negedge clk);
    chk("row7_in_shift", {sr_clk, row_sel, oe_n}, {1'b1, 16'h0000, 1'b1});
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk_reset("reset_mid_shift_now");
    @(posedge clk);
    @(negedge clk);
    chk_reset("reset_mid_shift_next");
`ifdef LED_DRIVER_BRIGHTNESS_EN
    brightness = 4'd3;
`endif
    words[0][0] = 32'hDEAD_BEEF;
    run(P + 2, 1'b0);
    chk("restart_row0_word", words[0][0], 32'hA5A5_0F0F);
    chk("restart_latch_count", latches, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
